// File: rtl/seg_page_sched_pkg.sv
// Shared types and helpers for the 7-seg page scheduler.
// Holds source count, word width, FSM state encoding and the page scan helpers.
package seg_sched_pkg;

    localparam int N_SRC  = 4;
    localparam int DATA_W = 24;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_SHOW  = 2'd1,
        ST_ALERT = 2'd2
    } sched_state_e;

    // First valid source after p, scanning p+1, p+2, p+3 (mod 4); p if none.
    function automatic logic [1:0] next_valid(input logic [N_SRC-1:0] vld,
                                              input logic [1:0]       p);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = p;
        found = 1'b0;
        for (int k = 1; k < N_SRC; k++) begin
            idx = p + 2'(k);
            if (!found && vld[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Lowest set index of a source mask; 0 when the mask is empty.
    function automatic logic [1:0] lowest_valid(input logic [N_SRC-1:0] vld);
        logic [1:0] res;
        res = 2'd0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (vld[k]) begin
                res = 2'(k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_page_sched_ms_tick_gen.sv
// Millisecond tick generator: counts 0..TICK_DIV-1 and pulses tick for one
// clock on the wrap cycle.
module ms_tick_gen #(
    parameter logic [15:0] TICK_DIV = 16'd50_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        wrap;

    assign wrap = (cnt_q == TICK_DIV - 16'd1);
    assign tick = wrap;

    // Free-running divider, wraps back to zero.
    always_comb begin
        cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
    end

    // Divider register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_page_sched.sv
// Display page scheduler for the DDS 6-digit 7-seg display.
// Picks one of four packed-BCD sources, cycles pages on key_next and briefly
// shows an updated source as an alert before returning to the home page.
// Optional feature: define AUTO_SCROLL_EN to advance the page every AUTO_MS
// ms ticks while showing a page.
//
// state    | meaning
// ST_EMPTY | no source valid, num forced to zero
// ST_SHOW  | showing page, changed by key / validity loss
// ST_ALERT | showing an updated source, returns to home on expiry or key
module seg_page_sched
    import seg_sched_pkg::*;
#(
    parameter logic [15:0] TICK_DIV = 16'd50_000,
    parameter logic [15:0] ALERT_MS = 16'd2_000,
    parameter logic [15:0] AUTO_MS  = 16'd5_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      key_next,
    input  logic [N_SRC-1:0]          src_vld,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    input  logic [N_SRC-1:0]          src_upd,
    output logic [DATA_W-1:0]         num,
    output logic [1:0]                page,
    output logic                      page_vld,
    output logic                      alert
);

    logic tick;

    sched_state_e      state_q, state_d;
    logic [1:0]        page_q, page_d;
    logic [1:0]        home_q, home_d;
    logic [15:0]       acnt_q, acnt_d;
    logic [DATA_W-1:0] num_q, num_d;
    logic              page_vld_q, page_vld_d;
    logic              alert_q, alert_d;
    logic [N_SRC-1:0]  upd_mask;
    logic              ret_home;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

`ifdef AUTO_SCROLL_EN
    logic [15:0] auto_q, auto_d;
    logic        auto_fire;
    assign auto_fire = tick && (auto_q == AUTO_MS - 16'd1);
`else
    logic unused_auto_ms;
    assign unused_auto_ms = ^AUTO_MS;
`endif

    // Updates that can pre-empt: valid source, not the one already on display.
    assign upd_mask = src_upd & src_vld & ~(4'b0001 << page_q);

    // Next-state, page selection and alert timer.
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        home_d   = home_q;
        acnt_d   = acnt_q;
        ret_home = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (|src_vld) begin
                    state_d = ST_SHOW;
                    page_d  = lowest_valid(src_vld);
                end
            end
            ST_SHOW: begin
                if (src_vld == '0) begin
                    state_d = ST_EMPTY;
                end else if (key_next) begin
                    page_d = next_valid(src_vld, page_q);
                end else if (!src_vld[page_q]) begin
                    page_d = next_valid(src_vld, page_q);
                end else if (|upd_mask) begin
                    state_d = ST_ALERT;
                    home_d  = page_q;
                    page_d  = lowest_valid(upd_mask);
                    acnt_d  = 16'd0;
`ifdef AUTO_SCROLL_EN
                end else if (auto_fire) begin
                    page_d = next_valid(src_vld, page_q);
`endif
                end
            end
            ST_ALERT: begin
                if (key_next || !src_vld[page_q]) begin
                    ret_home = 1'b1;
                end else if (|upd_mask) begin
                    page_d = lowest_valid(upd_mask);
                    acnt_d = 16'd0;
                end else if (tick) begin
                    if (acnt_q == ALERT_MS - 16'd1) begin
                        ret_home = 1'b1;
                    end else begin
                        acnt_d = acnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Leaving ALERT: go home if still valid, else the next valid page.
        if (ret_home) begin
            if (src_vld == '0) begin
                state_d = ST_EMPTY;
            end else begin
                state_d = ST_SHOW;
                page_d  = src_vld[home_q] ? home_q : next_valid(src_vld, home_q);
            end
        end
    end

`ifdef AUTO_SCROLL_EN
    // Auto-scroll timer: runs only while staying on the same SHOW page.
    always_comb begin
        auto_d = auto_q;
        if (state_d == ST_SHOW) begin
            if (state_q != ST_SHOW || key_next || page_d != page_q || auto_fire) begin
                auto_d = 16'd0;
            end else if (tick) begin
                auto_d = auto_q + 16'd1;
            end
        end
    end

    // Auto-scroll timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_q <= 16'd0;
        end else begin
            auto_q <= auto_d;
        end
    end
`endif

    // Output words: num follows live data of the current page one clock later.
    always_comb begin
        num_d      = (state_q != ST_EMPTY) ? src_data[DATA_W*int'(page_q) +: DATA_W]
                                           : '0;
        page_vld_d = (state_d != ST_EMPTY);
        alert_d    = (state_d == ST_ALERT);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            page_q     <= 2'd0;
            home_q     <= 2'd0;
            acnt_q     <= 16'd0;
            num_q      <= '0;
            page_vld_q <= 1'b0;
            alert_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            home_q     <= home_d;
            acnt_q     <= acnt_d;
            num_q      <= num_d;
            page_vld_q <= page_vld_d;
            alert_q    <= alert_d;
        end
    end

    assign num      = num_q;
    assign page     = page_q;
    assign page_vld = page_vld_q;
    assign alert    = alert_q;

endmodule

// File: tb/tb_seg_page_sched.sv
// Bench for seg_page_sched: fixed vector table, directed multi-cycle
// sequences, and randomized stimulus against a behavioural model.
module tb_seg_page_sched;

    localparam logic [15:0] TDIV = 16'd10;
    localparam logic [15:0] AMS  = 16'd3;
    localparam logic [15:0] AUTO = 16'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_next;
    logic [3:0]  src_vld;
    logic [95:0] src_data;
    logic [3:0]  src_upd;
    logic [23:0] num;
    logic [1:0]  page;
    logic        page_vld;
    logic        alert;

    int total = 0;
    int bad   = 0;

    // model: mode 0 = empty, 1 = show, 2 = alert
    int          m_mode, m_page, m_home, m_acnt, m_auto, m_tick;
    logic [23:0] m_num;

    seg_page_sched #(
        .TICK_DIV (TDIV),
        .ALERT_MS (AMS),
        .AUTO_MS  (AUTO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_next (key_next),
        .src_vld  (src_vld),
        .src_data (src_data),
        .src_upd  (src_upd),
        .num      (num),
        .page     (page),
        .page_vld (page_vld),
        .alert    (alert)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nextv(input logic [3:0] v, input int p);
        for (int k = 1; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return p;
    endfunction

    function automatic int lowest(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[k]) return k;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_page = 0; m_home = 0; m_acnt = 0; m_auto = 0; m_tick = 0;
        m_num  = '0;
    endtask

    task automatic go_home();
        if (src_vld == 4'b0000) begin
            m_mode = 0;
        end else begin
            m_mode = 1;
            m_page = src_vld[m_home] ? m_home : nextv(src_vld, m_home);
            m_auto = 0;
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        bit         tick;
        logic [3:0] um;
        tick   = (m_tick == int'(TDIV) - 1);
        m_tick = tick ? 0 : m_tick + 1;
        m_num  = (m_mode != 0) ? src_data[24*m_page +: 24] : 24'h0;
        um     = src_upd & src_vld;
        um[m_page] = 1'b0;
        case (m_mode)
            0: begin
                if (src_vld != 4'b0000) begin
                    m_mode = 1; m_page = lowest(src_vld); m_auto = 0;
                end
            end
            1: begin
                if (src_vld == 4'b0000) begin
                    m_mode = 0;
                end else if (key_next || !src_vld[m_page]) begin
                    m_page = nextv(src_vld, m_page); m_auto = 0;
                end else if (um != 4'b0000) begin
                    m_mode = 2; m_home = m_page; m_page = lowest(um); m_acnt = 0;
                end
`ifdef AUTO_SCROLL_EN
                else if (tick) begin
                    m_auto++;
                    if (m_auto == int'(AUTO)) begin
                        m_page = nextv(src_vld, m_page); m_auto = 0;
                    end
                end
`endif
            end
            default: begin
                if (key_next || !src_vld[m_page]) begin
                    go_home();
                end else if (um != 4'b0000) begin
                    m_page = lowest(um); m_acnt = 0;
                end else if (tick) begin
                    m_acnt++;
                    if (m_acnt == int'(AMS)) go_home();
                end
            end
        endcase
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_page"},  int'(page),     m_page);
        chk({tag, "_vld"},   int'(page_vld), int'(m_mode != 0));
        chk({tag, "_alert"}, int'(alert),    int'(m_mode == 2));
        chk({tag, "_num"},   int'(num),      int'(m_num));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        key_next = 1'b0;
        src_upd  = 4'b0000;
        src_vld  = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [23:0] rnd_bcd();
        logic [23:0] w;
        for (int d = 0; d < 6; d++) w[4*d +: 4] = 4'($urandom_range(0, 9));
        return w;
    endfunction

    typedef struct {
        logic [3:0]  vld;
        logic        key;
        logic [3:0]  upd;
        int          pg;
        logic        pv;
        logic        al;
        logic [23:0] nm;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int n;
        int s;
        tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 24'h000000};
        tbl[1]  = '{4'b0110, 1'b0, 4'b0000, 1, 1'b1, 1'b0, 24'h000000};
        tbl[2]  = '{4'b0110, 1'b0, 4'b0000, 1, 1'b1, 1'b0, 24'h222222};
        tbl[3]  = '{4'b1011, 1'b1, 4'b0000, 3, 1'b1, 1'b0, 24'h222222};
        tbl[4]  = '{4'b1011, 1'b1, 4'b0000, 0, 1'b1, 1'b0, 24'h444444};
        tbl[5]  = '{4'b1011, 1'b1, 4'b0000, 1, 1'b1, 1'b0, 24'h111111};
        tbl[6]  = '{4'b1011, 1'b1, 4'b0000, 3, 1'b1, 1'b0, 24'h222222};
        tbl[7]  = '{4'b0101, 1'b1, 4'b0000, 0, 1'b1, 1'b0, 24'h444444};
        tbl[8]  = '{4'b0101, 1'b1, 4'b0000, 2, 1'b1, 1'b0, 24'h111111};
        tbl[9]  = '{4'b0001, 1'b0, 4'b0000, 0, 1'b1, 1'b0, 24'h333333};
        tbl[10] = '{4'b0001, 1'b0, 4'b0001, 0, 1'b1, 1'b0, 24'h111111};
        tbl[11] = '{4'b0000, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 24'h111111};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 24'h000000};
        tbl[13] = '{4'b0011, 1'b1, 4'b0010, 0, 1'b1, 1'b0, 24'h000000};
        tbl[14] = '{4'b0011, 1'b1, 4'b0010, 1, 1'b1, 1'b0, 24'h111111};
        tbl[15] = '{4'b0011, 1'b0, 4'b0001, 0, 1'b1, 1'b1, 24'h222222};
        tbl[16] = '{4'b0011, 1'b1, 4'b0000, 1, 1'b1, 1'b0, 24'h111111};
        tbl[17] = '{4'b0011, 1'b0, 4'b0000, 1, 1'b1, 1'b0, 24'h222222};

        src_data = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        do_reset();
        #1;
        chk("reset_page", int'(page), 0);
        chk("reset_vld", int'(page_vld), 0);
        chk("reset_alert", int'(alert), 0);
        chk("reset_num", int'(num), 0);

        // vector table, one record per clock
        foreach (tbl[i]) begin
            src_vld  = tbl[i].vld;
            key_next = tbl[i].key;
            src_upd  = tbl[i].upd;
            step();
            chk($sformatf("tbl%0d_page", i), int'(page), tbl[i].pg);
            chk($sformatf("tbl%0d_vld", i), int'(page_vld), int'(tbl[i].pv));
            chk($sformatf("tbl%0d_alert", i), int'(alert), int'(tbl[i].al));
            chk($sformatf("tbl%0d_num", i), int'(num), int'(tbl[i].nm));
        end
        key_next = 1'b0;
        src_upd  = 4'b0000;

        // alert expiry after three ms ticks, back to home page
        do_reset();
        src_vld = 4'b1111;
        step();
        src_upd = 4'b0110;
        step();
        src_upd = 4'b0000;
        chk("alert_enter_page", int'(page), 1);
        chk("alert_enter_flag", int'(alert), 1);
        n = 0;
        while (alert && n < 60) begin
            step();
            n++;
        end
        chk("alert_expiry_window", int'(n >= 21 && n <= 30), 1);
        chk("alert_return_page", int'(page), 0);
        check_model("alert_ret");

        // asynchronous reset in the middle of an alert
        src_upd = 4'b0100;
        step();
        src_upd = 4'b0000;
        step();
        chk("pre_rst_num", int'(num), 24'h333333);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_page", int'(page), 0);
        chk("async_vld", int'(page_vld), 0);
        chk("async_alert", int'(alert), 0);
        chk("async_num", int'(num), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // idle with all sources valid: auto scroll only when built in
        src_vld = 4'b1111;
        for (int i = 0; i < 80; i++) begin
            step();
            check_model("auto");
        end
`ifndef AUTO_SCROLL_EN
        chk("no_auto_page", int'(page), 0);
`endif

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            key_next = ($urandom_range(0, 59) == 0);
            src_upd  = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 49) == 0) src_vld = 4'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                s = $urandom_range(0, 3);
                src_data[24*s +: 24] = rnd_bcd();
            end
            step();
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
